// File: rtl/clause_batch_fifo.sv
// Clause batch FIFO: queues whole clause batches (data + valid mask) and
// serialises the valid clauses, lowest index first, into one FWFT output FIFO.
// Batches leave in arrival order. A batch offered while the batch queue is full
// is dropped and counted in a sticky overflow flag and a saturating counter.
module clause_batch_fifo #(
  parameter int CLAUSE_COUNT = 20,
  parameter int CLAUSE_WIDTH = 9,
  parameter int BATCH_DEPTH  = 4,
  parameter int BUFFER_DEPTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0] clauses_i,
  input  logic [CLAUSE_COUNT-1:0]              clauses_valid_i,
  input  logic                                 wr_en_i,
  input  logic                                 rd_en_i,
  input  logic                                 cOF_i,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic                                 OF_o,
  output logic [CLAUSE_WIDTH-1:0]              clause_o,
  output logic [$clog2(BUFFER_DEPTH):0]        out_count_o,
  output logic [7:0]                           drop_cnt_o
);

  localparam int BQ_AW = $clog2(BATCH_DEPTH);
  localparam int OB_AW = $clog2(BUFFER_DEPTH);
  localparam int IDX_W = (CLAUSE_COUNT > 1) ? $clog2(CLAUSE_COUNT) : 1;
  localparam logic [BQ_AW:0] BQ_FULL = (BQ_AW+1)'(BATCH_DEPTH);
  localparam logic [OB_AW:0] OB_FULL = (OB_AW+1)'(BUFFER_DEPTH);

  typedef logic [CLAUSE_COUNT-1:0]                   mask_t;
  typedef logic [CLAUSE_COUNT-1:0][CLAUSE_WIDTH-1:0] batch_t;
  typedef enum logic {IDLE, DRAIN} state_t;

  localparam mask_t MASK_ONE = mask_t'(1);

  // Batch queue
  mask_t            bq_mask [BATCH_DEPTH];
  batch_t           bq_data [BATCH_DEPTH];
  logic [BQ_AW-1:0] bq_wr_ptr, bq_rd_ptr;
  logic [BQ_AW:0]   bq_count;

  // Serialiser
  state_t           state;
  mask_t            act_mask;
  batch_t           act_data;
  mask_t            rest_mask;
  logic [IDX_W-1:0] low_idx;

  // Output FIFO
  logic [CLAUSE_WIDTH-1:0] ob_mem [BUFFER_DEPTH];
  logic [OB_AW-1:0]        ob_wr_ptr, ob_rd_ptr;
  logic [OB_AW:0]          ob_count;

  logic offer, push, drop, pop, ob_write, ob_read, ob_full, bq_nonempty;

  // Full is taken from the occupancy count so a wrapped tail never aliases empty.
  assign full_o      = (bq_count == BQ_FULL);
  assign bq_nonempty = (bq_count != '0);
  assign offer       = wr_en_i && (clauses_valid_i != '0);
  assign push        = offer && !full_o;
  assign drop        = offer && full_o;

  assign ob_full     = (ob_count == OB_FULL);
  assign ob_write    = (state == DRAIN) && !ob_full;
  assign ob_read     = rd_en_i && (ob_count != '0);

  // Clearing the lowest set bit leaves the clauses still to be emitted.
  assign rest_mask   = act_mask & (act_mask - MASK_ONE);
  // Load the next batch from IDLE, or on the edge that emits the last clause.
  assign pop         = bq_nonempty && ((state == IDLE) || (ob_write && (rest_mask == '0)));

  // Priority encoder: index of the lowest valid clause still pending.
  always_comb begin
    // NOTE: default first so every path assigns low_idx and no latch is inferred.
    low_idx = '0;
    for (int j = CLAUSE_COUNT - 1; j >= 0; j--) begin
      if (act_mask[j]) low_idx = IDX_W'(j);
    end
  end

  // Batch queue pointers and occupancy.
  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so every block sees pre-edge values.
    if (rst_i) begin
      bq_wr_ptr <= '0;
      bq_rd_ptr <= '0;
      bq_count  <= '0;
    end else begin
      if (push) bq_wr_ptr <= bq_wr_ptr + BQ_AW'(1);
      if (pop)  bq_rd_ptr <= bq_rd_ptr + BQ_AW'(1);
      case ({push, pop})
        2'b10:   bq_count <= bq_count + (BQ_AW+1)'(1);
        2'b01:   bq_count <= bq_count - (BQ_AW+1)'(1);
        default: bq_count <= bq_count;
      endcase
    end
  end

  // Batch queue storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage arrays are not reset; the pointers and counts define what is valid.
    if (push) begin
      bq_mask[bq_wr_ptr] <= clauses_valid_i;
      bq_data[bq_wr_ptr] <= clauses_i;
    end
  end

  // Serialiser FSM: load a batch, then emit one clause per non-stalled edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      act_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            act_mask <= bq_mask[bq_rd_ptr];
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (ob_write) begin
            if (pop) begin
              act_mask <= bq_mask[bq_rd_ptr];
            end else begin
              act_mask <= rest_mask;
              if (rest_mask == '0) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Active batch data follows the mask load; contents are don't-care when idle.
  always_ff @(posedge clk_i) begin
    if (pop) act_data <= bq_data[bq_rd_ptr];
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ob_wr_ptr <= '0;
      ob_rd_ptr <= '0;
      ob_count  <= '0;
    end else begin
      if (ob_write) ob_wr_ptr <= ob_wr_ptr + OB_AW'(1);
      if (ob_read)  ob_rd_ptr <= ob_rd_ptr + OB_AW'(1);
      case ({ob_write, ob_read})
        2'b10:   ob_count <= ob_count + (OB_AW+1)'(1);
        2'b01:   ob_count <= ob_count - (OB_AW+1)'(1);
        default: ob_count <= ob_count;
      endcase
    end
  end

  // Output FIFO storage.
  always_ff @(posedge clk_i) begin
    if (ob_write) ob_mem[ob_wr_ptr] <= act_data[low_idx];
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      OF_o       <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      OF_o <= 1'b1;
      if (cOF_i)                    drop_cnt_o <= 8'd1;
      else if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
    end else if (cOF_i) begin
      OF_o       <= 1'b0;
      drop_cnt_o <= '0;
    end
  end

  assign empty_o     = (ob_count == '0);
  assign out_count_o = ob_count;
  assign clause_o    = empty_o ? '0 : ob_mem[ob_rd_ptr];

endmodule

// File: tb/tb_clause_batch_fifo.sv
// Testbench for clause_batch_fifo: directed scenarios plus randomized bursts,
// checked against an expected clause stream built from batch masks.
module tb_clause_batch_fifo;

  localparam int CC = 20;
  localparam int CW = 9;
  localparam int BD = 4;
  localparam int OD = 32;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [CC*CW-1:0]  clauses_i = '0;
  logic [CC-1:0]     clauses_valid_i = '0;
  logic              wr_en_i = 1'b0;
  logic              rd_en_i = 1'b0;
  logic              cOF_i = 1'b0;
  logic              empty_o, full_o, OF_o;
  logic [CW-1:0]     clause_o;
  logic [$clog2(OD):0] out_count_o;
  logic [7:0]        drop_cnt_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [CW-1:0] exp_q [$];

  always #5 clk = ~clk;

  clause_batch_fifo #(
    .CLAUSE_COUNT(CC), .CLAUSE_WIDTH(CW), .BATCH_DEPTH(BD), .BUFFER_DEPTH(OD)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clauses_i(clauses_i), .clauses_valid_i(clauses_valid_i),
    .wr_en_i(wr_en_i), .rd_en_i(rd_en_i), .cOF_i(cOF_i), .empty_o(empty_o),
    .full_o(full_o), .OF_o(OF_o), .clause_o(clause_o), .out_count_o(out_count_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [CC*CW-1:0] rand_data();
    logic [CC*CW-1:0] d;
    for (int j = 0; j < CC; j++) d[j*CW +: CW] = CW'($urandom);
    return d;
  endfunction

  // Reference: an accepted batch contributes its valid clauses in index order.
  task automatic model_accept(input logic [CC-1:0] mask, input logic [CC*CW-1:0] data);
    for (int j = 0; j < CC; j++) if (mask[j]) exp_q.push_back(data[j*CW +: CW]);
  endtask

  // Offer one batch for one edge; returns at the following negedge.
  task automatic drive_write(input logic [CC-1:0] mask, input logic [CC*CW-1:0] data);
    clauses_valid_i = mask;
    clauses_i       = data;
    wr_en_i         = 1'b1;
    @(negedge clk);
    wr_en_i         = 1'b0;
    clauses_valid_i = '0;
  endtask

  // Read everything the model expects, optionally with random read gaps.
  task automatic drain_and_compare(input string tag, input int budget, input bit random_rd);
    int cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      rd_en_i = random_rd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_en_i && !empty_o) begin
        logic [CW-1:0] e;
        e = exp_q.pop_front();
        total_cnt++;
        if (clause_o !== e) $display("FAIL %s_data: got %0h expected %0h", tag, clause_o, e);
        else pass_cnt++;
      end
      @(negedge clk);
      cycles++;
    end
    rd_en_i = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL %s_timeout: %0d clauses outstanding, expected 0", tag, exp_q.size());
    else pass_cnt++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    total_cnt++;
    if (empty_o !== 1'b1 || out_count_o !== '0)
      $display("FAIL %s_final_empty: empty=%b count=%0d expected empty=1 count=0", tag, empty_o, out_count_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty_o); else pass_cnt++;
    total_cnt++; if (full_o !== 1'b0) $display("FAIL reset_full: got %b expected 0", full_o); else pass_cnt++;
    total_cnt++; if (OF_o !== 1'b0) $display("FAIL reset_of: got %b expected 0", OF_o); else pass_cnt++;
    total_cnt++; if (clause_o !== '0) $display("FAIL reset_clause: got %0h expected 0", clause_o); else pass_cnt++;
    total_cnt++; if (out_count_o !== '0) $display("FAIL reset_count: got %0d expected 0", out_count_o); else pass_cnt++;
    total_cnt++; if (drop_cnt_o !== '0) $display("FAIL reset_drop: got %0d expected 0", drop_cnt_o); else pass_cnt++;
  endtask

  task automatic test_latency();
    logic [CC*CW-1:0] d = '0;
    d[0*CW +: CW] = 9'h011;
    d[2*CW +: CW] = 9'h022;
    drive_write(20'h00005, d);                     // E0 sampled
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL lat_e0_empty: got %b expected 1", empty_o); else pass_cnt++;
    @(negedge clk);                                // after E1 (load)
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL lat_e1_empty: got %b expected 1", empty_o); else pass_cnt++;
    @(negedge clk);                                // after E2 (first write)
    total_cnt++; if (empty_o !== 1'b0) $display("FAIL lat_e2_empty: got %b expected 0", empty_o); else pass_cnt++;
    total_cnt++; if (clause_o !== 9'h011) $display("FAIL lat_first: got %0h expected 11", clause_o); else pass_cnt++;
    rd_en_i = 1'b1;
    @(negedge clk);
    total_cnt++; if (clause_o !== 9'h022) $display("FAIL lat_second: got %0h expected 22", clause_o); else pass_cnt++;
    total_cnt++; if (out_count_o !== 1) $display("FAIL lat_rw_count: got %0d expected 1", out_count_o); else pass_cnt++;
    @(negedge clk);
    rd_en_i = 1'b0;
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL lat_end_empty: got %b expected 1", empty_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int waited = 0;
    for (int b = 0; b < 4; b++) begin
      logic [CC-1:0] m = '0;
      logic [CC*CW-1:0] d = rand_data();
      while ($countones(m) < 3) m[$urandom_range(0, CC-1)] = 1'b1;
      model_accept(m, d);
      drive_write(m, d);
    end
    while (empty_o && waited < 10) begin @(negedge clk); waited++; end
    rd_en_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [CW-1:0] e = exp_q.pop_front();
      total_cnt++;
      if (empty_o !== 1'b0 || clause_o !== e)
        $display("FAIL b2b_read%0d: empty=%b data=%0h expected empty=0 data=%0h", i, empty_o, clause_o, e);
      else pass_cnt++;
      @(negedge clk);
    end
    rd_en_i = 1'b0;
    exp_q.delete();
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL b2b_end_empty: got %b expected 1", empty_o); else pass_cnt++;
  endtask

  task automatic test_mask_zero();
    drive_write('0, rand_data());
    repeat (4) @(negedge clk);
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL mask0_empty: got %b expected 1", empty_o); else pass_cnt++;
    total_cnt++; if (OF_o !== 1'b0) $display("FAIL mask0_of: got %b expected 0", OF_o); else pass_cnt++;
    rd_en_i = 1'b1;
    repeat (2) @(negedge clk);
    rd_en_i = 1'b0;
    total_cnt++; if (out_count_o !== '0) $display("FAIL rd_empty_count: got %0d expected 0", out_count_o); else pass_cnt++;
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL rd_empty_empty: got %b expected 1", empty_o); else pass_cnt++;
  endtask

  // Stall the serialiser on a full output FIFO, then fill the batch queue.
  task automatic test_overflow();
    logic [CC*CW-1:0] d;
    int waited = 0;
    d = rand_data(); model_accept(20'hFFFFF, d); drive_write(20'hFFFFF, d);
    d = rand_data(); model_accept(20'h00FFF, d); drive_write(20'h00FFF, d);
    while (out_count_o != OD && waited < 80) begin @(negedge clk); waited++; end
    repeat (2) @(negedge clk);
    total_cnt++; if (out_count_o !== OD) $display("FAIL ovf_out_sat: got %0d expected %0d", out_count_o, OD); else pass_cnt++;
    total_cnt++; if (full_o !== 1'b0) $display("FAIL ovf_not_full: got %b expected 0", full_o); else pass_cnt++;
    for (int b = 0; b < 5; b++) begin              // one goes active, four fill the queue
      d = rand_data(); model_accept(20'hFFFFF, d); drive_write(20'hFFFFF, d);
    end
    total_cnt++; if (full_o !== 1'b1) $display("FAIL ovf_full: got %b expected 1", full_o); else pass_cnt++;
    total_cnt++; if (OF_o !== 1'b0) $display("FAIL ovf_of_before: got %b expected 0", OF_o); else pass_cnt++;
    drive_write(20'hFFFFF, rand_data());          // dropped
    total_cnt++; if (OF_o !== 1'b1) $display("FAIL ovf_of: got %b expected 1", OF_o); else pass_cnt++;
    total_cnt++; if (drop_cnt_o !== 8'd1) $display("FAIL ovf_drop: got %0d expected 1", drop_cnt_o); else pass_cnt++;
    total_cnt++; if (out_count_o !== OD) $display("FAIL ovf_held: got %0d expected %0d", out_count_o, OD); else pass_cnt++;
  endtask

  task automatic test_clear_of();
    cOF_i = 1'b1;
    @(negedge clk);
    cOF_i = 1'b0;
    total_cnt++; if (OF_o !== 1'b0) $display("FAIL clr_of: got %b expected 0", OF_o); else pass_cnt++;
    total_cnt++; if (drop_cnt_o !== 8'd0) $display("FAIL clr_drop: got %0d expected 0", drop_cnt_o); else pass_cnt++;
    cOF_i = 1'b1;
    drive_write(20'h00001, rand_data());          // drop and clear together
    cOF_i = 1'b0;
    total_cnt++; if (OF_o !== 1'b1) $display("FAIL clr_race_of: got %b expected 1", OF_o); else pass_cnt++;
    total_cnt++; if (drop_cnt_o !== 8'd1) $display("FAIL clr_race_drop: got %0d expected 1", drop_cnt_o); else pass_cnt++;
    clauses_valid_i = 20'h00010;
    wr_en_i = 1'b1;
    repeat (300) @(negedge clk);
    wr_en_i = 1'b0;
    clauses_valid_i = '0;
    total_cnt++; if (drop_cnt_o !== 8'd255) $display("FAIL drop_saturate: got %0d expected 255", drop_cnt_o); else pass_cnt++;
    cOF_i = 1'b1;
    @(negedge clk);
    cOF_i = 1'b0;
    total_cnt++; if (OF_o !== 1'b0 || drop_cnt_o !== 8'd0)
      $display("FAIL clr_after_sat: of=%b drop=%0d expected of=0 drop=0", OF_o, drop_cnt_o); else pass_cnt++;
    drain_and_compare("ovf_drain", 3000, 1'b1);
  endtask

  task automatic test_reset_mid_drain();
    logic [CC*CW-1:0] d;
    logic [CC-1:0] m;
    int waited = 0;
    drive_write(20'h003FF, rand_data());
    while (out_count_o < 3 && waited < 20) begin @(negedge clk); waited++; end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    total_cnt++; if (empty_o !== 1'b1 || out_count_o !== '0)
      $display("FAIL mid_rst: empty=%b count=%0d expected empty=1 count=0", empty_o, out_count_o); else pass_cnt++;
    total_cnt++; if (clause_o !== '0) $display("FAIL mid_rst_clause: got %0h expected 0", clause_o); else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++; if (empty_o !== 1'b1) $display("FAIL mid_rst_discard: got empty=%b expected 1", empty_o); else pass_cnt++;
    d = rand_data();
    m = CC'($urandom) | 20'h00001;
    model_accept(m, d);
    drive_write(m, d);
    drain_and_compare("post_rst", 200, 1'b0);
  endtask

  task automatic test_random();
    for (int burst = 0; burst < 25; burst++) begin
      int nb = $urandom_range(1, BD);
      for (int b = 0; b < nb; b++) begin
        logic [CC*CW-1:0] d = rand_data();
        logic [CC-1:0] m = CC'($urandom);
        if ($urandom_range(0, 1) == 1) m = m & CC'($urandom) & CC'($urandom);
        if ($urandom_range(0, 7) == 0) m = '0;
        model_accept(m, d);
        drive_write(m, d);
      end
      total_cnt++; if (OF_o !== 1'b0) $display("FAIL rnd_of_burst%0d: got %b expected 0", burst, OF_o); else pass_cnt++;
      drain_and_compare("rnd", 1000, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_mask_zero();
    test_overflow();
    test_clear_of();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
